// File: rtl/pixel_window_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_window_buffer
// Purpose  : 3-line x NCOL circular line buffer fed by one-hot column/line
//            selects; emits a registered 3x3 pixel window once two full
//            lines are held.
// Ports    : Phi1         - clock (rising edge)
//            Reset_b      - asynchronous active-low reset
//            pix_s1       - incoming pixel
//            pix_valid_s1 - pixel write request
//            colsel_s1    - one-hot column select
//            linesel_s1   - one-hot line select (001->010->100 rotation)
//            flush_s1     - synchronous restart of fill tracking
//            win_s1       - 3x3 window, element (r,k) at [(3r+k)*PIX_W +: PIX_W]
//            win_valid_s1 - win_s1 holds a fresh window this cycle
//            fill_s1      - fill state: 0 EMPTY, 1 ONE, 2 STREAM
//            sel_err_s1   - sticky illegal-select flag
// Revision : 1.0 - initial release
// ============================================================================
module pixel_window_buffer #(
    parameter int PIX_W = 8,
    parameter int NCOL  = 8
) (
    input  logic               Phi1,
    input  logic               Reset_b,
    input  logic [PIX_W-1:0]   pix_s1,
    input  logic               pix_valid_s1,
    input  logic [NCOL-1:0]    colsel_s1,
    input  logic [2:0]         linesel_s1,
    input  logic               flush_s1,
    output logic [9*PIX_W-1:0] win_s1,
    output logic               win_valid_s1,
    output logic [1:0]         fill_s1,
    output logic               sel_err_s1
);

    typedef enum logic [1:0] {
        S_EMPTY  = 2'd0,
        S_ONE    = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    localparam logic [NCOL-1:0] c_col_one  = NCOL'(1);
    localparam logic [2:0]      c_line_one = 3'd1;

    state_t               r_state;
    state_t               w_state_next;
    logic [PIX_W-1:0]     r_mem [3][NCOL];
    logic [9*PIX_W-1:0]   r_win;
    logic                 r_win_valid;
    logic                 r_sel_err;

    logic                 w_col_oh;
    logic                 w_line_oh;
    logic                 w_accept;
    logic                 w_illegal;
    logic                 w_line_end;
    logic                 w_col_ge2;
    logic                 w_emit;
    logic [2:0]           w_old_sel;
    logic [2:0]           w_mid_sel;
    logic [NCOL-1:0]      w_col_m1;
    logic [NCOL-1:0]      w_col_m2;
    logic [PIX_W-1:0]     w_rd  [3][3];
    logic [PIX_W-1:0]     w_old [3];
    logic [PIX_W-1:0]     w_mid [3];
    logic [PIX_W-1:0]     w_new [2];
    logic [9*PIX_W-1:0]   w_win_next;

    // ------------------------------------------------------------------
    // Write qualification
    // ------------------------------------------------------------------
    assign w_col_oh   = (colsel_s1 != '0) && ((colsel_s1 & (colsel_s1 - c_col_one)) == '0);
    assign w_line_oh  = (linesel_s1 != '0) && ((linesel_s1 & (linesel_s1 - c_line_one)) == '0);
    assign w_accept   = pix_valid_s1 && !flush_s1 && w_col_oh && w_line_oh;
    assign w_illegal  = pix_valid_s1 && !flush_s1 && !(w_col_oh && w_line_oh);
    assign w_line_end = colsel_s1[NCOL-1];
    // With a one-hot column, c>=2 simply means the two lowest bits are clear.
    assign w_col_ge2  = (colsel_s1[1:0] == 2'b00);
    assign w_emit     = w_accept && (r_state == S_STREAM) && w_col_ge2;

    // Older lines are rotations of the newest select; shifting the column
    // select down gives the c-1 and c-2 selects without any binary decode.
    assign w_mid_sel  = {linesel_s1[0], linesel_s1[2:1]};
    assign w_old_sel  = {linesel_s1[1:0], linesel_s1[2]};
    assign w_col_m1   = colsel_s1 >> 1;
    assign w_col_m2   = colsel_s1 >> 2;

    // ------------------------------------------------------------------
    // AND-OR read muxes
    // ------------------------------------------------------------------
    always_comb begin
        for (int l = 0; l < 3; l++) begin
            for (int k = 0; k < 3; k++) begin
                w_rd[l][k] = '0;
            end
            for (int c = 0; c < NCOL; c++) begin
                w_rd[l][0] = w_rd[l][0] | (r_mem[l][c] & {PIX_W{w_col_m2[c]}});
                w_rd[l][1] = w_rd[l][1] | (r_mem[l][c] & {PIX_W{w_col_m1[c]}});
                w_rd[l][2] = w_rd[l][2] | (r_mem[l][c] & {PIX_W{colsel_s1[c]}});
            end
        end
        for (int k = 0; k < 3; k++) begin
            w_old[k] = '0;
            w_mid[k] = '0;
            for (int l = 0; l < 3; l++) begin
                w_old[k] = w_old[k] | (w_rd[l][k] & {PIX_W{w_old_sel[l]}});
                w_mid[k] = w_mid[k] | (w_rd[l][k] & {PIX_W{w_mid_sel[l]}});
            end
        end
        // Newest line: only c-2 and c-1 come from storage; column c is the
        // pixel being written this very cycle and is bypassed.
        for (int k = 0; k < 2; k++) begin
            w_new[k] = '0;
            for (int l = 0; l < 3; l++) begin
                w_new[k] = w_new[k] | (w_rd[l][k] & {PIX_W{linesel_s1[l]}});
            end
        end
    end

    assign w_win_next = {pix_s1,   w_new[1], w_new[0],
                         w_mid[2], w_mid[1], w_mid[0],
                         w_old[2], w_old[1], w_old[0]};

    // ------------------------------------------------------------------
    // Fill-state machine
    // ------------------------------------------------------------------
    always_ff @(posedge Phi1 or negedge Reset_b) begin
        if (!Reset_b) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush_s1) begin
            w_state_next = S_EMPTY;
        end else if (w_accept && w_line_end) begin
            case (r_state)
                S_EMPTY:  w_state_next = S_ONE;
                S_ONE:    w_state_next = S_STREAM;
                S_STREAM: w_state_next = S_STREAM;
                default:  w_state_next = S_EMPTY;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    always_ff @(posedge Phi1 or negedge Reset_b) begin
        if (!Reset_b) begin
            for (int l = 0; l < 3; l++) begin
                for (int c = 0; c < NCOL; c++) begin
                    r_mem[l][c] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int l = 0; l < 3; l++) begin
                for (int c = 0; c < NCOL; c++) begin
                    if (linesel_s1[l] && colsel_s1[c]) begin
                        r_mem[l][c] <= pix_s1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Window output and error flag
    // ------------------------------------------------------------------
    always_ff @(posedge Phi1 or negedge Reset_b) begin
        if (!Reset_b) begin
            r_win       <= '0;
            r_win_valid <= 1'b0;
            r_sel_err   <= 1'b0;
        end else begin
            r_win_valid <= w_emit;
            if (w_emit) begin
                r_win <= w_win_next;
            end
            if (flush_s1) begin
                r_sel_err <= 1'b0;
            end else if (w_illegal) begin
                r_sel_err <= 1'b1;
            end
        end
    end

    assign win_s1       = r_win;
    assign win_valid_s1 = r_win_valid;
    assign fill_s1      = r_state;
    assign sel_err_s1   = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_pixel_window_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_window_buffer
// Purpose  : Self-checking bench for pixel_window_buffer; directed scenarios
//            followed by randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_window_buffer;

    localparam int PIX_W = 8;
    localparam int NCOL  = 8;

    logic               Phi1 = 1'b0;
    logic               Reset_b;
    logic [PIX_W-1:0]   pix_s1;
    logic               pix_valid_s1;
    logic [NCOL-1:0]    colsel_s1;
    logic [2:0]         linesel_s1;
    logic               flush_s1;
    logic [9*PIX_W-1:0] win_s1;
    logic               win_valid_s1;
    logic [1:0]         fill_s1;
    logic               sel_err_s1;

    pixel_window_buffer #(.PIX_W(PIX_W), .NCOL(NCOL)) dut (
        .Phi1         (Phi1),
        .Reset_b      (Reset_b),
        .pix_s1       (pix_s1),
        .pix_valid_s1 (pix_valid_s1),
        .colsel_s1    (colsel_s1),
        .linesel_s1   (linesel_s1),
        .flush_s1     (flush_s1),
        .win_s1       (win_s1),
        .win_valid_s1 (win_valid_s1),
        .fill_s1      (fill_s1),
        .sel_err_s1   (sel_err_s1)
    );

    always #5 Phi1 = ~Phi1;

    // Behavioural model: line buffer indexed by integer line/column.
    logic [PIX_W-1:0]   m_mem [3][NCOL];
    int                 m_fill;
    bit                 m_err;
    bit                 m_wv;
    logic [9*PIX_W-1:0] m_win;

    int n_pass  = 0;
    int n_total = 0;
    int n_win;

    task automatic check(input string tag, input logic [9*PIX_W-1:0] obs,
                         input logic [9*PIX_W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int l = 0; l < 3; l++)
            for (int c = 0; c < NCOL; c++)
                m_mem[l][c] = '0;
        m_fill = 0;
        m_err  = 0;
        m_wv   = 0;
        m_win  = '0;
    endtask

    // Index of the single set bit, or -1 when zero or several bits are set.
    function automatic int oh_index(input logic [NCOL-1:0] v);
        int idx = -1;
        if ($countones(v) == 1)
            for (int i = 0; i < NCOL; i++)
                if (v[i]) idx = i;
        return idx;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, 72'(win_valid_s1), 72'(m_wv));
        check({tag, ".fill"},  72'(fill_s1),      72'(m_fill));
        check({tag, ".err"},   72'(sel_err_s1),   72'(m_err));
        check({tag, ".win"},   win_s1,            m_win);
    endtask

    // One clock of stimulus; the model predicts what the DUT shows after it.
    task automatic step(input bit v, input logic [PIX_W-1:0] p,
                        input logic [NCOL-1:0] cs, input logic [2:0] ls,
                        input bit fl, input string tag);
        int  c, li, oldi, midi;
        bit  acc;
        pix_valid_s1 = v;
        pix_s1       = p;
        colsel_s1    = cs;
        linesel_s1   = ls;
        flush_s1     = fl;
        c   = oh_index(cs);
        li  = oh_index(NCOL'(ls));
        acc = v && !fl && (c >= 0) && (li >= 0);
        m_wv = 0;
        if (fl) begin
            m_fill = 0;
            m_err  = 0;
        end else begin
            if (v && !acc) m_err = 1;
            if (acc) begin
                if (m_fill == 2 && c >= 2) begin
                    oldi = (li + 1) % 3;
                    midi = (li + 2) % 3;
                    for (int k = 0; k < 3; k++) begin
                        m_win[k*PIX_W +: PIX_W]     = m_mem[oldi][c-2+k];
                        m_win[(3+k)*PIX_W +: PIX_W] = m_mem[midi][c-2+k];
                    end
                    m_win[6*PIX_W +: PIX_W] = m_mem[li][c-2];
                    m_win[7*PIX_W +: PIX_W] = m_mem[li][c-1];
                    m_win[8*PIX_W +: PIX_W] = p;
                    m_wv = 1;
                end
                m_mem[li][c] = p;
                if (c == NCOL-1 && m_fill < 2) m_fill++;
            end
        end
        @(posedge Phi1);
        #1;
        if (win_valid_s1) n_win++;
        check_outputs(tag);
    endtask

    task automatic write_line(input logic [2:0] ls, input logic [PIX_W-1:0] base,
                              input string tag);
        for (int c = 0; c < NCOL; c++)
            step(1'b1, base + PIX_W'(c), NCOL'(1) << c, ls, 1'b0, tag);
    endtask

    task automatic idle(input string tag);
        step(1'b0, '0, '0, 3'b000, 1'b0, tag);
    endtask

    initial begin
        Reset_b      = 1'b0;
        pix_s1       = '0;
        pix_valid_s1 = 1'b0;
        colsel_s1    = '0;
        linesel_s1   = '0;
        flush_s1     = 1'b0;
        model_reset();
        repeat (2) @(posedge Phi1);
        #1;
        check_outputs("reset");
        Reset_b = 1'b1;
        idle("idle");

        // Fill two lines; fill state walks 0->1->2 with no windows.
        n_win = 0;
        write_line(3'b001, 8'h10, "fill1");
        check("fill1.state", 72'(fill_s1), 72'd1);
        write_line(3'b010, 8'h20, "fill2");
        check("fill2.state", 72'(fill_s1), 72'd2);
        check("fill.nowin", 72'(n_win), 72'd0);

        // Stream line 100: six windows, first one checked against literals.
        n_win = 0;
        step(1'b1, 8'h30, 8'h01, 3'b100, 1'b0, "s3");
        step(1'b1, 8'h31, 8'h02, 3'b100, 1'b0, "s3");
        step(1'b1, 8'h32, 8'h04, 3'b100, 1'b0, "s3");
        check("stream.c2", win_s1, {8'h32, 8'h31, 8'h30, 8'h22, 8'h21, 8'h20,
                                    8'h12, 8'h11, 8'h10});
        for (int c = 3; c < NCOL; c++)
            step(1'b1, 8'h30 + 8'(c), 8'(1 << c), 3'b100, 1'b0, "s3");
        check("stream.count", 72'(n_win), 72'd6);

        // Rotation back to line 001.
        step(1'b1, 8'h40, 8'h01, 3'b001, 1'b0, "rot");
        step(1'b1, 8'h41, 8'h02, 3'b001, 1'b0, "rot");
        step(1'b1, 8'h42, 8'h04, 3'b001, 1'b0, "rot");
        check("rot.c2", win_s1, {8'h42, 8'h41, 8'h40, 8'h32, 8'h31, 8'h30,
                                 8'h22, 8'h21, 8'h20});

        // Asynchronous reset mid-line: outputs drop without a clock edge.
        step(1'b1, 8'h43, 8'h08, 3'b001, 1'b0, "rot");
        pix_valid_s1 = 1'b1;
        colsel_s1    = 8'h10;
        linesel_s1   = 3'b001;
        #2;
        Reset_b = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(posedge Phi1);
        #1;
        check_outputs("rst_hold");
        Reset_b = 1'b1;
        n_win = 0;
        write_line(3'b001, 8'h50, "refill1");
        write_line(3'b010, 8'h60, "refill2");
        step(1'b1, 8'h70, 8'h01, 3'b100, 1'b0, "refill3");
        step(1'b1, 8'h71, 8'h02, 3'b100, 1'b0, "refill3");
        check("refill.nowin", 72'(n_win), 72'd0);
        step(1'b1, 8'h72, 8'h04, 3'b100, 1'b0, "refill3");
        check("refill.first", 72'(win_valid_s1), 72'd1);

        // Illegal multi-hot select sets the sticky flag; flush clears it.
        step(1'b1, 8'hEE, 8'b00000110, 3'b100, 1'b0, "illegal");
        check("illegal.err", 72'(sel_err_s1), 72'd1);
        idle("illegal_hold");
        step(1'b1, 8'hEE, 8'h08, 3'b000, 1'b0, "illegal_line");
        step(1'b0, '0, '0, 3'b000, 1'b1, "flush");
        check("flush.err", 72'(sel_err_s1), 72'd0);
        check("flush.fill", 72'(fill_s1), 72'd0);

        // Flush with a simultaneous write: write dropped. Advance the state
        // with line-end writes only so the untouched columns become visible.
        step(1'b1, 8'hAB, 8'h02, 3'b001, 1'b1, "flushwr");
        check("flushwr.valid", 72'(win_valid_s1), 72'd0);
        step(1'b1, 8'h57, 8'h80, 3'b001, 1'b0, "le1");
        step(1'b1, 8'h67, 8'h80, 3'b010, 1'b0, "le2");
        step(1'b1, 8'h72, 8'h04, 3'b100, 1'b0, "flushwr_win");
        check("flushwr.mem", win_s1, {8'h72, 8'h71, 8'h70, 8'h62, 8'h61, 8'h60,
                                      8'h52, 8'h51, 8'h50});

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [NCOL-1:0] cs;
            logic [2:0]      ls;
            bit              v, fl;
            v  = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 39) == 0);
            cs = ($urandom_range(0, 15) == 0) ? NCOL'($urandom)
                                              : NCOL'(1) << $urandom_range(0, NCOL-1);
            ls = ($urandom_range(0, 15) == 0) ? 3'($urandom)
                                              : 3'd1 << $urandom_range(0, 2);
            step(v, PIX_W'($urandom), cs, ls, fl, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
